// File: rtl/dac_spi_drv.sv
// dac_spi_drv: serialises a 10-bit sample into a 12-bit SPI frame for a serial DAC
//   whenever the sample changes, or periodically when refresh is enabled.
// Ports:
//   s_clk      - system clock; every register updates on its rising edge
//   s_rst_n    - asynchronous active-low reset
//   dac_data   - 10-bit sample; may change on any cycle
//   dac_cs_n   - DAC chip select, active low
//   dac_sclk   - serial clock; the DAC samples dac_din on its rising edge
//   dac_din    - serial data, MSB first, frame = {dac_data, 2'b00}
//   busy       - high from the latch cycle until the end of the inter-frame gap
//   frame_done - one-cycle pulse on the cycle dac_cs_n returns high
// Build option: define DAC_REFRESH_EN to re-send the current sample every
//   REFRESH_TM+1 cycles even when it has not changed.
module dac_spi_drv #(
  parameter int SCLK_HALF  = 5,
  parameter int GAP_TM     = 10,
  parameter int REFRESH_TM = 999_999
) (
  input  logic       s_clk,
  input  logic       s_rst_n,
  input  logic [9:0] dac_data,
  output logic       dac_cs_n,
  output logic       dac_sclk,
  output logic       dac_din,
  output logic       busy,
  output logic       frame_done
);
  localparam int HW = $clog2(SCLK_HALF);
  localparam int GW = $clog2(GAP_TM + 2);
  localparam logic [HW-1:0] H_LD  = HW'(SCLK_HALF - 1);
  localparam logic [GW-1:0] G_END = GW'(GAP_TM);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t        r_state;
  logic [HW-1:0] r_hcnt;
  logic [3:0]    r_bcnt;
  logic [GW-1:0] r_gcnt;
  logic [11:0]   r_shift;
  logic [9:0]    r_prev;
  logic          r_pend;
  logic          w_latch;
  logic          w_change;
  logic          w_refresh;
  assign w_latch  = (r_state == IDLE) && r_pend;
  assign w_change = dac_data != r_prev;
  // The shift register MSB is the serial output, so the sample is never resampled mid-frame.
  assign dac_din  = r_shift[11];
`ifdef DAC_REFRESH_EN
  localparam int RW = $clog2(REFRESH_TM + 2);
  localparam logic [RW-1:0] R_END = RW'(REFRESH_TM);
  logic [RW-1:0] r_ref;
  assign w_refresh = r_ref == R_END;
  always_ff @(posedge s_clk or negedge s_rst_n)
    if (!s_rst_n) r_ref <= '0;
    else          r_ref <= w_refresh ? '0 : r_ref + 1'b1;
`else
  // Always false: refresh is not built in.
  assign w_refresh = REFRESH_TM < 0;
`endif
  // A change coinciding with the latch is absorbed: the latch takes the current value.
  always_ff @(posedge s_clk or negedge s_rst_n)
    if (!s_rst_n) begin
      r_prev <= '0;
      r_pend <= 1'b1;
    end else begin
      r_prev <= dac_data;
      r_pend <= !w_latch && (r_pend || w_change || w_refresh);
    end
  always_ff @(posedge s_clk or negedge s_rst_n)
    if (!s_rst_n) begin
      r_state    <= IDLE;
      r_hcnt     <= '0;
      r_bcnt     <= '0;
      r_gcnt     <= '0;
      r_shift    <= '0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        IDLE: if (r_pend) begin
          r_shift  <= {dac_data, 2'b00};
          r_hcnt   <= H_LD;
          r_bcnt   <= '0;
          busy     <= 1'b1;
          dac_cs_n <= 1'b0;
          r_state  <= SETUP;
        end
        SETUP: if (r_hcnt == '0) begin
          r_hcnt  <= H_LD;
          r_state <= SHIFT;
        end else r_hcnt <= r_hcnt - 1'b1;
        // Each half-period ends by toggling sclk; data advances only on the falling toggle.
        SHIFT: if (r_hcnt != '0) r_hcnt <= r_hcnt - 1'b1;
        else begin
          r_hcnt   <= H_LD;
          dac_sclk <= !dac_sclk;
          if (dac_sclk) begin
            if (r_bcnt == 4'd11) r_state <= HOLD;
            else begin
              r_bcnt  <= r_bcnt + 1'b1;
              r_shift <= {r_shift[10:0], 1'b0};
            end
          end
        end
        HOLD: if (r_hcnt == '0) begin
          dac_cs_n   <= 1'b1;
          frame_done <= 1'b1;
          r_bcnt     <= '0;
          r_gcnt     <= '0;
          r_state    <= GAP;
        end else r_hcnt <= r_hcnt - 1'b1;
        GAP: if (r_gcnt == G_END) begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end else r_gcnt <= r_gcnt + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dac_spi_drv.sv
// tb_dac_spi_drv: directed self-checking bench for dac_spi_drv
module tb_dac_spi_drv;
  localparam int SH  = 5;
  localparam int GAP = 10;
  logic       s_clk = 1'b0;
  logic       s_rst_n = 1'b0;
  logic [9:0] dac_data = '0;
  logic       dac_cs_n, dac_sclk, dac_din, busy, frame_done;
  always #5 s_clk = ~s_clk;
  dac_spi_drv #(.SCLK_HALF(SH), .GAP_TM(GAP), .REFRESH_TM(999)) dut (
    .s_clk(s_clk), .s_rst_n(s_rst_n), .dac_data(dac_data),
    .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_din(dac_din),
    .busy(busy), .frame_done(frame_done)
  );
  int n_chk = 0, n_fail = 0, cyc = 0, n_fall = 0, n_fd = 0, nbits = 0;
  int fall_cyc = 0, rise_cyc = -1000, low_len = 0, fd_cyc = 0;
  logic [11:0] bits = '0;
  logic p_sclk = 1'b0, p_cs = 1'b1, p_din = 1'b0;
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge s_clk);
    #1;
    cyc++;
    if (dac_sclk) chk("din_stable_sclk_high", dac_din, p_din);
    if (!p_sclk && dac_sclk) begin
      bits = {bits[10:0], p_din};
      nbits++;
    end
    if (p_cs && !dac_cs_n) begin
      chk("sclk_at_cs_fall", dac_sclk, 0);
      chk("busy_at_cs_fall", busy, 1);
      chk("cs_high_gap", int'(cyc - rise_cyc >= GAP), 1);
      n_fall++;
      fall_cyc = cyc;
      nbits = 0;
      bits = '0;
    end
    if (!p_cs && dac_cs_n) begin
      chk("sclk_at_cs_rise", dac_sclk, 0);
      rise_cyc = cyc;
      low_len = cyc - fall_cyc;
    end
    if (frame_done) begin
      chk("frame_done_at_cs_rise", {p_cs, dac_cs_n}, 2'b01);
      n_fd++;
      fd_cyc = cyc;
    end
    p_sclk = dac_sclk;
    p_cs = dac_cs_n;
    p_din = dac_din;
  endtask
  task automatic wait_fd(input string tag);
    int n0 = n_fd;
    int k = 0;
    while (n_fd == n0 && k < 3000) begin
      tick();
      k++;
    end
    chk(tag, n_fd - n0, 1);
  endtask
  task automatic wait_fall(input string tag);
    int n0 = n_fall;
    int k = 0;
    while (n_fall == n0 && k < 1500) begin
      tick();
      k++;
    end
    chk(tag, n_fall - n0, 1);
  endtask
  initial begin
    int rel, c, fd1, f1, nf, nfd0, k;
    repeat (3) tick();
    chk("rst_cs_n", dac_cs_n, 1);
    chk("rst_sclk", dac_sclk, 0);
    chk("rst_din", dac_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    s_rst_n = 1'b1;
    rel = cyc;
    wait_fd("f0_done");
    chk("f0_fall_after_release", fall_cyc - rel, 1);
    chk("f0_bits", bits, 12'h000);
    chk("f0_nbits", nbits, 12);
    chk("f0_cs_low", low_len, 26 * SH);
    chk("f0_fd_latency", fd_cyc - fall_cyc, 26 * SH);
    repeat (40) tick();
    chk("idle_busy", busy, 0);
    chk("idle_cs_n", dac_cs_n, 1);
    chk("idle_one_frame", n_fall, 1);
`ifdef DAC_REFRESH_EN
    dac_data = 10'h155;
    wait_fall("r0_start");
    wait_fall("r1_start");
    f1 = fall_cyc;
    wait_fall("r2_start");
    chk("refresh_period", fall_cyc - f1, 1000);
    repeat (200) tick();
    chk("refresh_bits", bits, 12'h554);
    chk("refresh_nbits", nbits, 12);
`else
    dac_data = 10'h2A5;
    c = cyc;
    wait_fd("f1_done");
    chk("f1_latch_delay", fall_cyc - c, 2);
    chk("f1_bits", bits, 12'hA94);
    chk("f1_nbits", nbits, 12);
    chk("f1_cs_low", low_len, 26 * SH);
    dac_data = 10'h3FF;
    wait_fall("f2_start");
    repeat (20) tick();
    dac_data = 10'h001;
    repeat (10) tick();
    dac_data = 10'h002;
    repeat (10) tick();
    dac_data = 10'h003;
    wait_fd("f2_done");
    chk("f2_bits", bits, 12'hFFC);
    fd1 = fd_cyc;
    wait_fd("f3_done");
    chk("f3_fall_after_fd", fall_cyc - fd1, GAP + 2);
    chk("f3_bits", bits, 12'h00C);
    chk("f3_cs_low", low_len, 26 * SH);
    nf = n_fall;
    repeat (200) tick();
    chk("f3_single_frame", n_fall, nf);
    dac_data = 10'h0F0;
    c = cyc;
    tick();
    dac_data = 10'h30F;
    wait_fd("f4_done");
    chk("f4_latch_delay", fall_cyc - c, 2);
    chk("f4_bits", bits, 12'hC3C);
    nf = n_fall;
    repeat (200) tick();
    chk("f4_no_extra_frame", n_fall, nf);
    dac_data = 10'h155;
    wait_fall("f5_start");
    k = 0;
    while (nbits != 6 && k < 500) begin
      tick();
      k++;
    end
    chk("f5_at_bit6", nbits, 6);
    s_rst_n = 1'b0;
    #1;
    chk("abort_cs_n", dac_cs_n, 1);
    chk("abort_sclk", dac_sclk, 0);
    chk("abort_busy", busy, 0);
    nfd0 = n_fd;
    repeat (15) tick();
    chk("abort_no_frame_done", n_fd, nfd0);
    s_rst_n = 1'b1;
    rel = cyc;
    wait_fd("f6_done");
    chk("f6_fall_after_release", fall_cyc - rel, 1);
    chk("f6_bits", bits, 12'h554);
    chk("f6_cs_low", low_len, 26 * SH);
    nf = n_fall;
    repeat (2500) tick();
    chk("no_refresh_frames", n_fall, nf);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dac_spi_drv.md
DAC_SPI_DRV -- requirements
Module: dac_spi_drv

Interface
REQ-001 The block SHALL have parameter SCLK_HALF, default 5, meaning the s_clk cycles per dac_sclk half-period (must be 2..255).
REQ-002 The block SHALL have parameter GAP_TM, default 10, meaning the minimum s_clk cycles dac_cs_n stays high between frames.
REQ-003 The block SHALL have parameter REFRESH_TM, default 999_999, meaning the s_clk cycles between forced refresh frames (used only with DAC_REFRESH_EN).
REQ-004 Port s_clk, input, 1 bit: the single system clock; every register SHALL be clocked on its rising edge.
REQ-005 Port s_rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-006 Port dac_data, input, 10 bits: the sample to convert, driven by the ramp generator; it may change on any cycle.
REQ-007 Port dac_cs_n, output, 1 bit: serial DAC chip select, active low.
REQ-008 Port dac_sclk, output, 1 bit: serial clock; the DAC samples dac_din on its rising edge.
REQ-009 Port dac_din, output, 1 bit: serial data, MSB first.
REQ-010 Port busy, output, 1 bit: high from the latch cycle until the end of the gap.
REQ-011 Port frame_done, output, 1 bit: a one-cycle pulse on the cycle dac_cs_n returns high.

Function
REQ-012 Change detection: each cycle, dac_data SHALL be compared with register data_prev; if they differ, pending SHALL be set and data_prev SHALL be updated.
REQ-013 The FSM SHALL have states IDLE, SETUP, SHIFT, HOLD and GAP.
REQ-014 IDLE: when pending=1, the block SHALL load a 12-bit shift register with {dac_data, 2'b00}, clear pending, set busy and go to SETUP (the latch cycle = N).
REQ-015 A dac_data change on the latch cycle SHALL be absorbed, because the current value is the one latched, and SHALL NOT cause an extra frame.
REQ-016 SETUP: dac_cs_n SHALL be low from N+1, with dac_sclk=0 and dac_din=bit11, for SCLK_HALF cycles.
REQ-017 SHIFT: for each of the 12 bits, dac_sclk SHALL be low for SCLK_HALF cycles and then high for SCLK_HALF cycles.
REQ-018 SHIFT: dac_din SHALL change only on the s_clk cycle where dac_sclk falls, never while dac_sclk is high.
REQ-019 SHIFT: a 4-bit bit counter SHALL count 0..11; after the 12th high phase the FSM SHALL go to HOLD.
REQ-020 HOLD: dac_sclk=0 and dac_cs_n=0 SHALL be held for SCLK_HALF cycles, then dac_cs_n SHALL go high, frame_done SHALL pulse for 1 cycle, and the FSM SHALL go to GAP.
REQ-021 Total dac_cs_n low time SHALL be 26*SCLK_HALF cycles (130 at default).
REQ-022 GAP: dac_cs_n SHALL stay high for GAP_TM cycles, then busy SHALL drop and the FSM SHALL return to IDLE.
REQ-023 A pending request SHALL be serviced on the IDLE cycle after GAP.
REQ-024 Changes during a frame: any number of changes SHALL collapse into one pending frame, which carries the latest dac_data at the latch cycle.
REQ-025 The half-period counter SHALL be width ceil(log2(SCLK_HALF)) and SHALL reload at SCLK_HALF-1; it SHALL be held at 0 in IDLE and GAP.
REQ-026 dac_data SHALL NOT be resampled inside a frame; the shift register alone drives dac_din.

Reset
REQ-027 Reset values SHALL be: dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0, frame_done=0, FSM=IDLE, counters=0, shift register=0, data_prev=0.
REQ-028 pending SHALL reset to 1, so the first frame after reset release sends the current dac_data (including 0).
REQ-029 Reset asserted mid-frame SHALL force the reset values immediately (asynchronously); the partial frame SHALL be abandoned, with no frame_done.

Configuration
REQ-030 With macro DAC_REFRESH_EN defined, a refresh counter (0..REFRESH_TM) SHALL run continuously and set pending on wrap, so the current value is re-sent even when unchanged.
REQ-031 A refresh coinciding with a data change SHALL yield one pending frame.
REQ-032 Without DAC_REFRESH_EN, the refresh counter logic SHALL be absent, and frames SHALL start only after reset and on dac_data change.

Verification
REQ-033 Release reset with dac_data=10'h000 -> one frame, dac_din bits all 0, cs_n low for 130 cycles, frame_done at cycle 131 after latch, then idle.
REQ-034 Set dac_data=10'h2A5 in idle -> sampled bits on sclk rising edges = 1010100101_00, with 12 rising edges per frame.
REQ-035 Change dac_data to 10'h001, 10'h002, 10'h003 during a frame -> exactly one following frame, carrying 10'h003, whose latch occurs GAP_TM+1 cycles after frame_done.
REQ-036 Assert s_rst_n low at bit 6 of a frame -> dac_cs_n=1, dac_sclk=0 immediately; after release, a new full frame of the current dac_data, with no frame_done for the aborted frame.
REQ-037 With DAC_REFRESH_EN, REFRESH_TM=999 and constant dac_data=10'h155 -> a frame starts every 1000 cycles; without the macro -> no frame after the initial one.
REQ-038 Protocol check for all tests -> dac_din stable while dac_sclk is high, dac_sclk=0 whenever dac_cs_n falls or rises, and cs_n high time >= GAP_TM.
